// File: rtl/memory_access_pkg.sv
// Shared memory-stage types: access size, controller state and bus geometry.
package memory_access_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    RSVD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/memory_access_load_align.sv
// Pure combinational load extraction: picks the byte/half/word lane and extends it.
module load_align
  import memory_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (mem_size_e'(size_i))
      BYTE:    result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      HALF:    result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-stage data-access controller: issues one req/ack transaction per load/store,
// stalls the pipe while it is outstanding and returns the extended load value.
module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_m_i,
  input  logic        mem_write_m_i,
  input  logic [1:0]  size_m_i,
  input  logic        unsigned_m_i,
  input  logic [31:0] alu_out_m_i,
  input  logic [31:0] write_data_m_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] read_data_m_o,
  output logic        stall_o,
  output logic        misaligned_o
);

  mem_state_e  state_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] rbuf_q;
  logic [31:0] rdata_q;

  logic        mem_op;
  logic        access;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] align_out;

  // Reset masks the combinational request path so nothing leaks out while held in reset.
  assign mem_op = (mem_read_m_i | mem_write_m_i) & ~rst_i;

  always_comb begin
    misaligned_o = 1'b0;
    if (mem_op) begin
      case (mem_size_e'(size_m_i))
        BYTE:    misaligned_o = 1'b0;
        HALF:    misaligned_o = alu_out_m_i[0];
        default: misaligned_o = |alu_out_m_i[1:0];
      endcase
    end
  end

  assign access = mem_op & ~misaligned_o;

  always_comb begin
    be_d    = 4'b0000;
    wdata_d = write_data_m_i;
    if (mem_write_m_i) begin
      case (mem_size_e'(size_m_i))
        BYTE: begin
          be_d    = 4'b0001 << alu_out_m_i[1:0];
          wdata_d = {WORD_BYTES{write_data_m_i[7:0]}};
        end
        HALF: begin
          be_d    = alu_out_m_i[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{write_data_m_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = write_data_m_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q <= WAIT;
            we_q    <= mem_write_m_i;
            addr_q  <= {alu_out_m_i[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= alu_out_m_i[1:0];
            size_q  <= size_m_i;
            uns_q   <= unsigned_m_i;
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            state_q <= DONE;
            if (!we_q) rbuf_q <= dmem_rdata_i;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (!we_q) rdata_q <= align_out;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  load_align u_load_align (
    .word_i     (rbuf_q),
    .addr_i     (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (align_out)
  );

  // IDLE presents the request straight from the stage inputs; WAIT replays the captured copy.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = mem_write_m_i;
          dmem_addr_o  = {alu_out_m_i[31:2], 2'b00};
          dmem_be_o    = be_d;
          dmem_wdata_o = wdata_d;
        end
      end
      WAIT: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = we_q;
        dmem_addr_o  = addr_q;
        dmem_be_o    = be_q;
        dmem_wdata_o = wdata_q;
      end
      default: ;
    endcase
  end

  assign stall_o       = ((state_q == IDLE) & access) | (state_q == WAIT);
  assign read_data_m_o = ((state_q == DONE) && !we_q) ? align_out : rdata_q;

endmodule
